// File: rtl/i2c_bus_arbiter.sv
// Shares one I2C master between the write engine (requester 0) and the read engine
// (requester 1): grant, command mux, ack gating, master reset between owners, watchdog.
module i2c_bus_arbiter #(
    parameter int TIMEOUT      = 4096,
    parameter int RESET_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1,
    input  logic [6:0] r0_slave_address,
    input  logic [7:0] r0_byte,
    input  logic       r0_mode,
    input  logic       r0_en,
    input  logic       r0_start,
    input  logic       r0_stop,
    input  logic       r0_repeat_start,
    input  logic [6:0] r1_slave_address,
    input  logic [7:0] r1_byte,
    input  logic       r1_mode,
    input  logic       r1_en,
    input  logic       r1_start,
    input  logic       r1_stop,
    input  logic       r1_repeat_start,
    output logic [6:0] slave_address,
    output logic [7:0] byte_to_be_writen,
    output logic       I2C_mode,
    output logic       I2C_en,
    output logic       I2C_start,
    output logic       I2C_stop,
    output logic       I2C_repeat_start,
    output logic       reset_I2C,
    input  logic       ack,
    output logic       ack0,
    output logic       ack1,
    output logic       timeout,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int RW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT0  = 2'd1,
        GRANT1  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic [RW-1:0] rc_cnt_q, rc_cnt_d;
    logic          last_owner_q, last_owner_d;
    logic          lockout0_q, lockout0_d;
    logic          lockout1_q, lockout1_d;
    logic          timeout_q, timeout_d;
    logic          rst_hold_q, rst_hold_d;

    logic elig0, elig1, own_req;

    // Handshake: an engine holds reqN high for its whole transaction and may use the
    // master only while gntN is high; dropping reqN ends the transaction.
    assign elig0   = req0 & ~lockout0_q;
    assign elig1   = req1 & ~lockout1_q;
    assign own_req = (state_q == GRANT1) ? req1 : req0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            wd_cnt_q     <= '0;
            rc_cnt_q     <= '0;
            last_owner_q <= 1'b1;
            lockout0_q   <= 1'b0;
            lockout1_q   <= 1'b0;
            timeout_q    <= 1'b0;
            rst_hold_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            wd_cnt_q     <= wd_cnt_d;
            rc_cnt_q     <= rc_cnt_d;
            last_owner_q <= last_owner_d;
            lockout0_q   <= lockout0_d;
            lockout1_q   <= lockout1_d;
            timeout_q    <= timeout_d;
            rst_hold_q   <= rst_hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wd_cnt_d     = wd_cnt_q;
        rc_cnt_d     = rc_cnt_q;
        last_owner_d = last_owner_q;
        // A lockout survives only while its request stays high.
        lockout0_d   = lockout0_q & req0;
        lockout1_d   = lockout1_q & req1;
        timeout_d    = 1'b0;
        rst_hold_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // The first cycle out of reset only releases reset_I2C; no arbitration yet.
                if (!rst_hold_q) begin
                    if (elig0 && elig1) begin
                        state_d = last_owner_q ? GRANT0 : GRANT1;
                    end else if (elig0) begin
                        state_d = GRANT0;
                    end else if (elig1) begin
                        state_d = GRANT1;
                    end
                    wd_cnt_d = '0;
                end
            end
            GRANT0, GRANT1: begin
                if (!own_req) begin
                    state_d      = RECOVER;
                    rc_cnt_d     = '0;
                    last_owner_d = (state_q == GRANT1);
                end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d      = RECOVER;
                    rc_cnt_d     = '0;
                    last_owner_d = (state_q == GRANT1);
                    timeout_d    = 1'b1;
                    if (state_q == GRANT1) begin
                        lockout1_d = 1'b1;
                    end else begin
                        lockout0_d = 1'b1;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            RECOVER: begin
                if (rc_cnt_q == RW'(RESET_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    rc_cnt_d = rc_cnt_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slave_address     = '0;
        byte_to_be_writen = '0;
        I2C_mode          = 1'b0;
        I2C_en            = 1'b0;
        I2C_start         = 1'b0;
        I2C_stop          = 1'b0;
        I2C_repeat_start  = 1'b0;
        reset_I2C         = 1'b0;
        case (state_q)
            IDLE:    reset_I2C = ~rst_hold_q;
            GRANT0: begin
                slave_address     = r0_slave_address;
                byte_to_be_writen = r0_byte;
                I2C_mode          = r0_mode;
                I2C_en            = r0_en;
                I2C_start         = r0_start;
                I2C_stop          = r0_stop;
                I2C_repeat_start  = r0_repeat_start;
                reset_I2C         = 1'b1;
            end
            GRANT1: begin
                slave_address     = r1_slave_address;
                byte_to_be_writen = r1_byte;
                I2C_mode          = r1_mode;
                I2C_en            = r1_en;
                I2C_start         = r1_start;
                I2C_stop          = r1_stop;
                I2C_repeat_start  = r1_repeat_start;
                reset_I2C         = 1'b1;
            end
            default: reset_I2C = 1'b0;
        endcase
    end

    assign gnt0      = (state_q == GRANT0);
    assign gnt1      = (state_q == GRANT1);
    assign ack0      = ack & gnt0;
    assign ack1      = ack & gnt1;
    assign timeout   = timeout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: grant events go through an expected queue checked
// by a monitor; mux, reset and timing details are checked inline against fixed values.
module tb_i2c_bus_arbiter;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RECOVER = 2'd3;

    logic       clk;
    logic       reset;
    logic       req0, req1;
    logic       gnt0, gnt1;
    logic [6:0] r0_slave_address, r1_slave_address;
    logic [7:0] r0_byte, r1_byte;
    logic       r0_mode, r0_en, r0_start, r0_stop, r0_repeat_start;
    logic       r1_mode, r1_en, r1_start, r1_stop, r1_repeat_start;
    logic [6:0] slave_address;
    logic [7:0] byte_to_be_writen;
    logic       I2C_mode, I2C_en, I2C_start, I2C_stop, I2C_repeat_start;
    logic       reset_I2C;
    logic       ack, ack0, ack1;
    logic       timeout;
    logic [1:0] dbg_state;

    logic [2:0] exp_q[$];
    int         n_checks;
    int         n_err;

    i2c_bus_arbiter #(.TIMEOUT(16), .RESET_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
        .r0_slave_address(r0_slave_address), .r0_byte(r0_byte), .r0_mode(r0_mode),
        .r0_en(r0_en), .r0_start(r0_start), .r0_stop(r0_stop),
        .r0_repeat_start(r0_repeat_start),
        .r1_slave_address(r1_slave_address), .r1_byte(r1_byte), .r1_mode(r1_mode),
        .r1_en(r1_en), .r1_start(r1_start), .r1_stop(r1_stop),
        .r1_repeat_start(r1_repeat_start),
        .slave_address(slave_address), .byte_to_be_writen(byte_to_be_writen),
        .I2C_mode(I2C_mode), .I2C_en(I2C_en), .I2C_start(I2C_start), .I2C_stop(I2C_stop),
        .I2C_repeat_start(I2C_repeat_start), .reset_I2C(reset_I2C),
        .ack(ack), .ack0(ack0), .ack1(ack1), .timeout(timeout), .dbg_state(dbg_state)
    );

    // Clock and reset-time defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] master_vec();
        return {slave_address, byte_to_be_writen, I2C_mode, I2C_en, I2C_start,
                I2C_stop, I2C_repeat_start};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 4 ns after the rising edge; inline checks happen at the same point.
    task automatic step();
        @(posedge clk);
        #4;
    endtask

    task automatic wait_grant(input int limit, output int cyc, output logic [1:0] who);
        cyc = limit + 1;
        who = 2'b00;
        for (int c = 1; c <= limit; c++) begin
            step();
            if (gnt0 || gnt1) begin
                cyc = c;
                who = {gnt1, gnt0};
                break;
            end
        end
    endtask

    // Monitor: every new non-idle {timeout, gnt1, gnt0} pattern must match the queue head.
    initial begin
        logic [2:0] prev, cur, e;
        prev = 3'b000;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cur = {timeout, gnt1, gnt0};
            if (cur != prev && cur != 3'b000) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_event: got %b, expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_event", 32'(cur), 32'(e));
                end
            end
            prev = cur;
        end
    end

    initial begin
        int         c;
        int         seen;
        logic [1:0] who;

        n_checks = 0;
        n_err    = 0;
        reset = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        ack  = 1'b0;
        r0_slave_address = 7'h2A; r0_byte = 8'hC5;
        r0_mode = 1'b1; r0_en = 1'b0; r0_start = 1'b0; r0_stop = 1'b1; r0_repeat_start = 1'b1;
        r1_slave_address = 7'h00; r1_byte = 8'h00;
        r1_mode = 1'b0; r1_en = 1'b0; r1_start = 1'b0; r1_stop = 1'b0; r1_repeat_start = 1'b0;

        // Reset held for three edges with both requests up.
        step(); step(); step();
        check("rst_gnt", {gnt1, gnt0}, 0);
        check("rst_master", master_vec(), 0);
        check("rst_reset_i2c", reset_I2C, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", dbg_state, S_IDLE);
        exp_q.push_back(3'b001);
        reset = 1'b1;
        step();
        check("post_rst_idle_gnt", {gnt1, gnt0}, 0);
        check("post_rst_reset_i2c", reset_I2C, 1);
        check("post_rst_state", dbg_state, S_IDLE);
        step();
        check("first_tie_gnt", {gnt1, gnt0}, 2'b01);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t1_back_idle", dbg_state, S_IDLE);

        // Single owner on requester 1: mux, ack gating, release into recovery.
        exp_q.push_back(3'b010);
        req1 = 1'b1; r1_slave_address = 7'h50; r1_byte = 8'h03;
        r1_start = 1'b1; r1_en = 1'b1; ack = 1'b1;
        step();
        check("r1_gnt", {gnt1, gnt0}, 2'b10);
        check("r1_mux", master_vec(), {7'h50, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        check("r1_reset_i2c", reset_I2C, 1);
        check("r1_acks", {ack1, ack0}, 2'b10);
        r1_start = 1'b0;
        r1_byte  = 8'hA7;
        req1     = 1'b0;
        #2;
        check("r1_mux_zero_latency", master_vec(), {7'h50, 8'hA7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("recover_lines", {gnt1, gnt0, reset_I2C}, 0);
            check("recover_master", master_vec(), 0);
        end
        step();
        check("after_recover_state", dbg_state, S_IDLE);
        check("after_recover_reset_i2c", reset_I2C, 1);

        // Round robin with both engines re-requesting right after each release.
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        exp_q.push_back(3'b001); exp_q.push_back(3'b010);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_grant(20, c, who);
        check("rr_first_latency", c, 1);
        check("rr_first_owner", who, 2'b01);
        for (int i = 1; i <= 3; i++) begin
            if ((i % 2) == 1) req0 = 1'b0; else req1 = 1'b0;
            step();
            req0 = 1'b1;
            req1 = 1'b1;
            wait_grant(20, c, who);
            check("rr_gap", c, 5);
            check("rr_owner", who, ((i % 2) == 1) ? 2'b10 : 2'b01);
        end

        // Watchdog: requester 0 hangs, gets cut off and locked out.
        exp_q.push_back(3'b001); exp_q.push_back(3'b100); exp_q.push_back(3'b010);
        req1 = 1'b0;
        wait_grant(20, c, who);
        check("wd_grant_gap", c, 6);
        check("wd_grant_owner", who, 2'b01);
        c = 41;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (timeout) begin
                c = i;
                break;
            end
        end
        check("wd_latency", c, 16);
        check("wd_gnt0_dropped", gnt0, 0);
        check("wd_state", dbg_state, S_RECOVER);
        req1 = 1'b1;
        step();
        check("wd_pulse_width", timeout, 0);
        wait_grant(20, c, who);
        check("wd_other_latency", c, 4);
        check("wd_other_owner", who, 2'b10);
        req1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (gnt0 || gnt1) seen++;
        end
        check("lockout_no_grant", seen, 0);
        exp_q.push_back(3'b001);
        req0 = 1'b0;
        step();
        req0 = 1'b1;
        wait_grant(20, c, who);
        check("lockout_cleared_latency", c, 1);
        check("lockout_cleared_owner", who, 2'b01);

        // Reset in the middle of a requester-1 transaction.
        exp_q.push_back(3'b010);
        req0  = 1'b0;
        req1  = 1'b1;
        r1_en = 1'b1;
        wait_grant(20, c, who);
        check("mid_grant_gap", c, 6);
        check("mid_grant_owner", who, 2'b10);
        check("mid_en_before", I2C_en, 1);
        reset = 1'b0;
        req1  = 1'b0;
        step();
        check("mid_rst_gnt1", gnt1, 0);
        check("mid_rst_en", I2C_en, 0);
        check("mid_rst_reset_i2c", reset_I2C, 0);
        check("mid_rst_state", dbg_state, S_IDLE);
        reset = 1'b1;
        step(); step(); step();
        check("events_all_seen", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/i2c_bus_arbiter.md
# i2c_bus_arbiter

Two-requester arbiter that shares the single I2C master between the memory write engine (requester 0) and the memory read engine (requester 1). It grants the master to one engine at a time and muxes that engine's command bundle onto the master inputs. It gates `ack` back to the owner only, and resets the master between owners. A watchdog reclaims the bus from a hung owner.

## Interface
Parameters:
- TIMEOUT, 4096: maximum cycles one grant may last before forced release (≥ 2).
- RESET_CYCLES, 4: cycles `reset_I2C` is held low between owners (≥ 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req0, req1  in  1  bus request from write engine / read engine; held high for the whole transaction.
- gnt0, gnt1  out  1  registered grant; at most one high.
- rN_slave_address  in  7  slave address from requester N (N = 0, 1).
- rN_byte  in  8  write byte from requester N.
- rN_mode, rN_en, rN_start, rN_stop, rN_repeat_start  in  1 each  I2C command bits from requester N.
- slave_address  out  7  to I2C master.
- byte_to_be_writen  out  8  to I2C master.
- I2C_mode, I2C_en, I2C_start, I2C_stop, I2C_repeat_start  out  1 each  to I2C master.
- reset_I2C  out  1  active-low reset to I2C master.
- ack  in  1  acknowledge from I2C master.
- ack0, ack1  out  1  `ack & gntN`.
- timeout  out  1  one-cycle pulse on watchdog release.

## Operation
- States: IDLE, GRANT0, GRANT1, RECOVER.
- IDLE: grant lines low. Master inputs are all 0, except `reset_I2C` = 1.
  - Single eligible request: go to GRANTN.
  - Both eligible: grant the requester that is not `last_owner`.
- GRANTN: `gntN` = 1. Master outputs are driven combinationally from requester N's bundle, and `reset_I2C` = 1. The watchdog counter increments every cycle.
- Normal release: `reqN` sampled low in GRANTN → RECOVER. Set `last_owner` = N.
- Watchdog release: counter = TIMEOUT−1 with `reqN` still high → RECOVER. Then:
  - pulse `timeout`;
  - set `last_owner` = N;
  - set `lockoutN`. Requester N is ineligible until `reqN` is sampled low, which clears `lockoutN`.
- RECOVER: both grants low. Master inputs are 0 and `reset_I2C` = 0 for exactly RESET_CYCLES cycles, then go to IDLE.
- Eligible means `reqN` is high and `lockoutN` is clear. Requests arriving during GRANT or RECOVER wait and are evaluated in IDLE.
- Counter is $clog2(TIMEOUT) bits wide and clears on entry to GRANTN. It cannot wrap, because it saturates at release.
- Reset (`reset` sampled low), including mid-transaction:
  - state IDLE, counter 0, `last_owner` = 1 (requester 0 wins first tie), lockouts clear;
  - grants 0, `timeout` 0, all master outputs 0, `reset_I2C` = 0.
  - The first IDLE cycle after reset drives `reset_I2C` = 1.

## Timing
- Request to grant: `reqN` high in cycle k with the arbiter in IDLE → `gntN` = 1 in cycle k+1. The bundle is muxed in the same cycle k+1.
- Mux latency: zero cycles combinational from `rN_*` to master outputs while `gntN` = 1.
- Release to reset:
  - `reqN` low in cycle k → `gntN` = 0 and `reset_I2C` = 0 in cycles k+1 … k+RESET_CYCLES;
  - IDLE in cycle k+RESET_CYCLES+1;
  - the next grant, if any request is pending, appears in cycle k+RESET_CYCLES+2.
- Watchdog: grant first high in cycle g and `reqN` held high → `timeout` = 1 and `gntN` = 0 in cycle g+TIMEOUT.
- `ack0`/`ack1`: combinational, zero latency.
- Back-to-back requests from the same requester always pass through RECOVER; there is no grant extension.

## Test plan
- Reset: hold `reset` = 0 for 3 cycles with `req0` = `req1` = 1 → gnt0 = gnt1 = 0, all master outputs 0, `reset_I2C` = 0. First cycle after release: IDLE with `reset_I2C` = 1. Next cycle: gnt0 = 1 (tie goes to 0).
- Single owner, mux, release:
  - Stimulus: `req1` high, `r1_slave_address` = 7'h50, `r1_byte` = 8'h03, `r1_start` pulse, `ack` = 1.
  - Required during grant: gnt1 = 1 one cycle later; outputs mirror the r1 bundle; `ack1` = 1, `ack0` = 0.
  - Then drop `req1` → `reset_I2C` low for exactly 4 cycles, then IDLE.
- Round robin: both requests held continuously → grants alternate 0, 1, 0, 1. Each grant is separated by 4 RECOVER cycles plus 1 IDLE cycle.
- Watchdog with TIMEOUT = 16:
  - Stimulus: `req0` stuck high.
  - Required: `timeout` pulses 16 cycles after gnt0 rose; gnt0 never reasserts while `req0` stays high; `req1` is granted after RECOVER.
  - Then lower and raise `req0` → it is eligible again.
- Mid-transaction reset: assert `reset` during GRANT1 with `r1_en` = 1 → the next cycle has gnt1 = 0, `I2C_en` = 0, `reset_I2C` = 0, state IDLE.
